// File: rtl/inst_decode.sv
// Instruction decode stage: a small FIFO queue in front of a registered
// RV32I decode bundle handed to dispatch over a valid/ready handshake.
module inst_decode #(
    parameter int INST_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  inst_valid,
    input  logic [INST_WIDTH-1:0] inst,
    output logic                  inst_vacant,
    input  logic                  dec_ready,
    output logic                  dec_valid,
    output logic [3:0]            dec_class,
    output logic [4:0]            dec_rd,
    output logic [4:0]            dec_rs1,
    output logic [4:0]            dec_rs2,
    output logic [2:0]            dec_funct3,
    output logic                  dec_funct7b5,
    output logic [31:0]           dec_imm
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_OP_IMM  = 4'd7;
    localparam logic [3:0] CLS_OP      = 4'd8;
    localparam logic [3:0] CLS_FENCE   = 4'd9;
    localparam logic [3:0] CLS_SYSTEM  = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    // Opcode to instruction class; anything unrecognised (including
    // compressed encodings with opcode[1:0] != 2'b11) is ILLEGAL.
    function automatic logic [3:0] f_class(input logic [6:0] opc);
        logic [3:0] cls;
        case (opc)
            7'b0110111: cls = CLS_LUI;
            7'b0010111: cls = CLS_AUIPC;
            7'b1101111: cls = CLS_JAL;
            7'b1100111: cls = CLS_JALR;
            7'b1100011: cls = CLS_BRANCH;
            7'b0000011: cls = CLS_LOAD;
            7'b0100011: cls = CLS_STORE;
            7'b0010011: cls = CLS_OP_IMM;
            7'b0110011: cls = CLS_OP;
            7'b0001111: cls = CLS_FENCE;
            7'b1110011: cls = CLS_SYSTEM;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Immediate assembly per encoding format, sign-extended to 32 bits.
    function automatic logic [31:0] f_imm(input logic [3:0] cls, input logic [31:7] w);
        logic [31:0] imm;
        case (cls)
            CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_SYSTEM:
                imm = {{20{w[31]}}, w[31:20]};
            CLS_STORE:
                imm = {{20{w[31]}}, w[31:25], w[11:7]};
            CLS_BRANCH:
                imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                imm = {w[31:12], 12'h000};
            CLS_JAL:
                imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:
                imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    logic [INST_WIDTH-1:0] r_mem [QUEUE_DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;

    logic                  r_dec_valid;
    logic [3:0]            r_dec_class;
    logic [4:0]            r_dec_rd;
    logic [4:0]            r_dec_rs1;
    logic [4:0]            r_dec_rs2;
    logic [2:0]            r_dec_funct3;
    logic                  r_dec_funct7b5;
    logic [31:0]           r_dec_imm;

    logic                  w_vacant;
    logic                  w_push;
    logic                  w_load;
    logic [INST_WIDTH-1:0] w_head;
    logic [3:0]            w_class;
    logic [31:0]           w_imm;
    logic [4:0]            w_rd;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;

    // Vacancy comes from the registered count only, so a pop in the same
    // cycle never reopens a full queue and there is no path from dec_ready.
    assign w_vacant = (r_count != FULL_CNT);
    assign w_push   = inst_valid && w_vacant && !flush;
    assign w_load   = (r_count != {CW{1'b0}}) && (!r_dec_valid || dec_ready) && !flush;

    // Decode of the queue head, with register indices zeroed where unused.
    always_comb begin
        w_head  = r_mem[r_rd_ptr];
        w_class = f_class(w_head[6:0]);
        w_imm   = f_imm(w_class, w_head[31:7]);
        case (w_class)
            CLS_BRANCH, CLS_STORE, CLS_FENCE, CLS_ILLEGAL: w_rd = 5'd0;
            default:                                       w_rd = w_head[11:7];
        endcase
        case (w_class)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_FENCE, CLS_ILLEGAL: w_rs1 = 5'd0;
            default:                                             w_rs1 = w_head[19:15];
        endcase
        case (w_class)
            CLS_BRANCH, CLS_STORE, CLS_OP: w_rs2 = w_head[24:20];
            default:                       w_rs2 = 5'd0;
        endcase
    end

    // Queue storage; data needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= inst;
        end
    end

    // Queue pointers and occupancy; flush empties the queue like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output bundle register: load from the head, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid    <= 1'b0;
            r_dec_class    <= 4'd0;
            r_dec_rd       <= 5'd0;
            r_dec_rs1      <= 5'd0;
            r_dec_rs2      <= 5'd0;
            r_dec_funct3   <= 3'd0;
            r_dec_funct7b5 <= 1'b0;
            r_dec_imm      <= 32'h0000_0000;
        end else if (flush) begin
            r_dec_valid <= 1'b0;
        end else if (w_load) begin
            r_dec_valid    <= 1'b1;
            r_dec_class    <= w_class;
            r_dec_rd       <= w_rd;
            r_dec_rs1      <= w_rs1;
            r_dec_rs2      <= w_rs2;
            r_dec_funct3   <= w_head[14:12];
            r_dec_funct7b5 <= w_head[30];
            r_dec_imm      <= w_imm;
        end else if (r_dec_valid && dec_ready) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign inst_vacant  = w_vacant;
    assign dec_valid    = r_dec_valid;
    assign dec_class    = r_dec_class;
    assign dec_rd       = r_dec_rd;
    assign dec_rs1      = r_dec_rs1;
    assign dec_rs2      = r_dec_rs2;
    assign dec_funct3   = r_dec_funct3;
    assign dec_funct7b5 = r_dec_funct7b5;
    assign dec_imm      = r_dec_imm;

endmodule

// File: tb/tb_inst_decode.sv
// Directed and randomised checks of the inst_decode queue and decoder.
module tb_inst_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_vacant;
    logic        dec_ready;
    logic        dec_valid;
    logic [3:0]  dec_class;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic        dec_funct7b5;
    logic [31:0] dec_imm;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [15];

    inst_decode #(.INST_WIDTH(32), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .inst_vacant(inst_vacant),
        .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_class(dec_class),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_funct3(dec_funct3), .dec_funct7b5(dec_funct7b5), .dec_imm(dec_imm)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dec(input string tag, input vec_t v);
        check({tag, ".valid"}, 32'(dec_valid), 32'd1);
        check({tag, ".class"}, 32'(dec_class), 32'(v.cls));
        check({tag, ".rd"},    32'(dec_rd),    32'(v.rd));
        check({tag, ".rs1"},   32'(dec_rs1),   32'(v.rs1));
        check({tag, ".rs2"},   32'(dec_rs2),   32'(v.rs2));
        check({tag, ".f3"},    32'(dec_funct3), 32'(v.f3));
        check({tag, ".f7b5"},  32'(dec_funct7b5), 32'(v.f7));
        check({tag, ".imm"},   dec_imm,        v.imm);
    endtask

    function automatic logic [31:0] addi_word(input int k);
        return {12'(k), 5'd0, 3'd0, 5'(k), 7'b0010011};
    endfunction

    initial begin
        logic [31:0] mq [$];
        logic [31:0] m_out;
        logic        m_valid;
        logic [18:0] seq;
        logic        iv, fl, rdy, e_push, e_load;
        logic [31:0] word;
        int          accepted;

        //            inst          cls    rd     rs1    rs2    f3    f7    imm
        vecs[0]  = '{32'h00500093, 4'd7,  5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000005};
        vecs[1]  = '{32'h12345137, 4'd0,  5'd2,  5'd0,  5'd0,  3'd5, 1'b0, 32'h12345000};
        vecs[2]  = '{32'hFE208EE3, 4'd4,  5'd0,  5'd1,  5'd2,  3'd0, 1'b1, 32'hFFFFFFFC};
        vecs[3]  = '{32'h0020A423, 4'd6,  5'd0,  5'd1,  5'd2,  3'd2, 1'b0, 32'h00000008};
        vecs[4]  = '{32'hFF9FF0EF, 4'd2,  5'd1,  5'd0,  5'd0,  3'd7, 1'b1, 32'hFFFFFFF8};
        vecs[5]  = '{32'h00008067, 4'd3,  5'd0,  5'd1,  5'd0,  3'd0, 1'b0, 32'h00000000};
        vecs[6]  = '{32'hFFFFF297, 4'd1,  5'd5,  5'd0,  5'd0,  3'd7, 1'b1, 32'hFFFFF000};
        vecs[7]  = '{32'hFFF3A303, 4'd5,  5'd6,  5'd7,  5'd0,  3'd2, 1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{32'h40A48433, 4'd8,  5'd8,  5'd9,  5'd10, 3'd0, 1'b1, 32'h00000000};
        vecs[9]  = '{32'h0FF1928F, 4'd9,  5'd0,  5'd0,  5'd0,  3'd1, 1'b0, 32'h00000000};
        vecs[10] = '{32'hC00021F3, 4'd10, 5'd3,  5'd0,  5'd0,  3'd2, 1'b1, 32'hFFFFFC00};
        vecs[11] = '{32'hFE20AE23, 4'd6,  5'd0,  5'd1,  5'd2,  3'd2, 1'b1, 32'hFFFFFFFC};
        vecs[12] = '{32'h00000000, 4'd15, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};
        vecs[13] = '{32'h0000007F, 4'd15, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};
        vecs[14] = '{32'hFFFFFFFF, 4'd15, 5'd0,  5'd0,  5'd0,  3'd7, 1'b1, 32'h00000000};

        // Reset with a concurrent flush.
        rst = 1'b1; flush = 1'b1; inst_valid = 1'b0; inst = 32'h0; dec_ready = 1'b0;
        step(); step();
        rst = 1'b0; flush = 1'b0;
        check("rst.valid",  32'(dec_valid),   32'd0);
        check("rst.vacant", 32'(inst_vacant), 32'd1);
        check("rst.class",  32'(dec_class),   32'd0);
        check("rst.rd",     32'(dec_rd),      32'd0);
        check("rst.imm",    dec_imm,          32'd0);

        // 1: two-cycle latency for a single addi.
        inst_valid = 1'b1; inst = vecs[0].inst;
        step();
        inst_valid = 1'b0;
        check("t1.lat", 32'(dec_valid), 32'd0);
        step();
        check_dec("t1", vecs[0]);

        // 2: back-to-back stream with dec_ready high.
        dec_ready = 1'b1; inst_valid = 1'b1; inst = vecs[1].inst;
        step();
        check("t2.gap", 32'(dec_valid), 32'd0);
        inst = vecs[2].inst;
        step();
        check_dec("t2.lui", vecs[1]);
        inst = vecs[3].inst;
        step();
        check_dec("t2.beq", vecs[2]);
        inst_valid = 1'b0;
        step();
        check_dec("t2.sw", vecs[3]);
        step();
        check("t2.end", 32'(dec_valid), 32'd0);

        // 3: fill with the output stalled; then drain in order.
        dec_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            if (!inst_vacant || accepted >= 6) break;
            inst_valid = 1'b1; inst = addi_word(accepted + 1);
            step();
            accepted++;
        end
        check("t3.accepted", 32'(accepted), 32'd5);
        inst = addi_word(6);
        for (int c = 0; c < 3; c++) begin
            check("t3.full",   32'(inst_vacant), 32'd0);
            check("t3.frz.rd", 32'(dec_rd),      32'd1);
            check("t3.frz.im", dec_imm,          32'd1);
            step();
        end
        inst_valid = 1'b0; dec_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check("t3.drain.v",  32'(dec_valid), 32'd1);
            check("t3.drain.rd", 32'(dec_rd),    32'(k));
            check("t3.drain.im", dec_imm,        32'(k));
        end
        check("t3.vacant", 32'(inst_vacant), 32'd1);
        step();
        check("t3.empty", 32'(dec_valid), 32'd0);

        // 4: flush with three queued, valid output and a concurrent push.
        dec_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            inst_valid = 1'b1; inst = addi_word(k);
            step();
        end
        check("t4.pre.v",  32'(dec_valid), 32'd1);
        check("t4.pre.rd", 32'(dec_rd),    32'd10);
        flush = 1'b1; inst = addi_word(20);
        step();
        flush = 1'b0; inst_valid = 1'b0;
        check("t4.flush.v",  32'(dec_valid),   32'd0);
        check("t4.flush.vc", 32'(inst_vacant), 32'd1);
        step();
        check("t4.nodrop", 32'(dec_valid), 32'd0);
        inst_valid = 1'b1; inst = addi_word(21);
        step();
        inst_valid = 1'b0;
        step();
        check("t4.new.v",  32'(dec_valid), 32'd1);
        check("t4.new.rd", 32'(dec_rd),    32'd21);
        dec_ready = 1'b1;
        step();
        check("t4.end", 32'(dec_valid), 32'd0);

        // 5: class/immediate sweep including illegal encodings.
        for (int i = 4; i < 15; i++) begin
            inst_valid = 1'b1; inst = vecs[i].inst;
            step();
            inst_valid = 1'b0;
            step();
            check_dec($sformatf("t5.v%0d", i), vecs[i]);
            step();
        end

        // 6: random push/pop/flush traffic against a reference queue.
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_valid = 1'b0; m_out = 32'h0; seq = 19'd0;
        for (int c = 0; c < 10000; c++) begin
            iv  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            word = {1'b0, seq[18], 5'd0, seq[14:10], seq[9:5], seq[17:15], seq[4:0], 7'b0110011};
            inst_valid = iv; flush = fl; dec_ready = rdy; inst = word;
            check("t6.vacant", 32'(inst_vacant), 32'(mq.size() != 4));
            e_push = iv && (mq.size() != 4) && !fl;
            e_load = (mq.size() != 0) && (!m_valid || rdy) && !fl;
            step();
            if (fl) begin
                mq.delete();
                m_valid = 1'b0;
            end else begin
                if (e_load) begin
                    m_out = mq.pop_front();
                    m_valid = 1'b1;
                end else if (m_valid && rdy) begin
                    m_valid = 1'b0;
                end
                if (e_push) begin
                    mq.push_back(word);
                    seq = seq + 19'd1;
                end
            end
            check("t6.valid", 32'(dec_valid), 32'(m_valid));
            if (m_valid) begin
                check("t6.fields",
                      32'({dec_class, dec_funct7b5, dec_funct3, dec_rs2, dec_rs1, dec_rd}),
                      32'({4'd8, m_out[30], m_out[14:12], m_out[24:20], m_out[19:15], m_out[11:7]}));
            end
        end
        inst_valid = 1'b0; flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
